// File: rtl/cnn_pkg.sv
// Shared defaults and types for the convolution window reader.
// The image, kernel and pixel sizes here are the defaults the reader is normally built with.
package cnn_pkg;

   localparam int IMG_W     = 28;
   localparam int K         = 5;
   localparam int OUT_W     = IMG_W - K + 1;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 10;
   localparam int TAP_COUNT = OUT_W * OUT_W * K * K;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } win_state_t;

endpackage

// File: rtl/win_skid_buf.sv
// Two-entry FIFO between the image memory read port and the tap consumer.
// Entry 0 is always the head, so the outputs come straight from a register.
module win_skid_buf #(
   parameter int DATA_W = cnn_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last_win,
   input  logic              in_last_img,
   output logic [1:0]        occupancy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last_win,
   output logic              out_last_img
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              lastWin;
      logic              lastImg;
   } entry_t;

   entry_t head, tail, inEntry;
   logic   push, pop;

   assign inEntry      = '{data: in_data, lastWin: in_last_win, lastImg: in_last_img};
   assign push         = in_valid;
   assign pop          = out_valid & out_ready;
   assign out_valid    = (occupancy != 2'd0);
   assign out_data     = head.data;
   assign out_last_win = head.lastWin;
   assign out_last_img = head.lastImg;

   // The producer throttles its reads, so a push never lands on a full buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy <= 2'd0;
         head      <= '0;
         tail      <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occupancy == 2'd0) head <= inEntry;
               else                   tail <= inEntry;
               occupancy <= occupancy + 2'd1;
            end
            2'b01: begin
               head      <= tail;
               occupancy <= occupancy - 2'd1;
            end
            2'b11: begin
               if (occupancy == 2'd1) begin
                  head <= inEntry;
               end else begin
                  head <= tail;
                  tail <= inEntry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/img_win_read.sv
// Walks every KxK window of the image, issuing one memory read per tap,
// and streams the taps out through a small buffer with valid/ready handshaking.
module img_win_read #(
   parameter int IMG_W  = cnn_pkg::IMG_W,
   parameter int K      = cnn_pkg::K,
   parameter int DATA_W = cnn_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              rd_en,
   output logic [9:0]        rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_last_win,
   output logic              pix_last_img,
   output logic              busy,
   output logic              done
);

   import cnn_pkg::*;

   localparam int OW = IMG_W - K + 1;

   win_state_t state, nextState;

   logic [9:0] kc, kr, outCol, outRow;
   logic [9:0] addrNow, addrHold;
   logic       kcWrap, krWrap, colWrap, rowWrap, winLast, imgLast;
   logic       inflight, inflightLastWin, inflightLastImg;
   logic [1:0] occupancy;
   logic       xfer;
   logic [2:0] pending;

   assign kcWrap  = (kc == 10'(K - 1));
   assign krWrap  = (kr == 10'(K - 1));
   assign colWrap = (outCol == 10'(OW - 1));
   assign rowWrap = (outRow == 10'(OW - 1));
   assign winLast = kcWrap & krWrap;
   assign imgLast = winLast & colWrap & rowWrap;

   assign addrNow = (outRow + kr) * 10'(IMG_W) + outCol + kc;
   assign xfer    = pix_valid & pix_ready;
   assign pending = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, xfer};
   assign rd_addr = rd_en ? addrNow : addrHold;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // A read may only issue if its data is guaranteed a free slot when it returns.
   always_comb begin
      nextState = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = RUN;
         end
         RUN: begin
            busy  = 1'b1;
            rd_en = (pending < 3'd2);
            if (rd_en && imgLast) nextState = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (xfer && pix_last_img) nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Nested index counters, kc fastest; they wrap back to zero after the last tap.
   always_ff @(posedge clk) begin
      if (reset) begin
         kc     <= '0;
         kr     <= '0;
         outCol <= '0;
         outRow <= '0;
      end else if (rd_en) begin
         kc <= kcWrap ? 10'd0 : kc + 10'd1;
         if (kcWrap) kr <= krWrap ? 10'd0 : kr + 10'd1;
         if (winLast) outCol <= colWrap ? 10'd0 : outCol + 10'd1;
         if (winLast && colWrap) outRow <= rowWrap ? 10'd0 : outRow + 10'd1;
      end
   end

   // Tap flags travel alongside the read so they arrive with the returning data.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight        <= 1'b0;
         inflightLastWin <= 1'b0;
         inflightLastImg <= 1'b0;
         addrHold        <= '0;
      end else begin
         inflight        <= rd_en;
         inflightLastWin <= rd_en & winLast;
         inflightLastImg <= rd_en & imgLast;
         if (rd_en) addrHold <= addrNow;
      end
   end

   win_skid_buf #(.DATA_W(DATA_W)) u_buf (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (inflight),
      .in_data      (rd_data),
      .in_last_win  (inflightLastWin),
      .in_last_img  (inflightLastImg),
      .occupancy    (occupancy),
      .out_valid    (pix_valid),
      .out_ready    (pix_ready),
      .out_data     (pix_data),
      .out_last_win (pix_last_win),
      .out_last_img (pix_last_img)
   );

endmodule

// File: doc/img_win_read.md
IMG_WIN_READ -- requirements
Module: img_win_read

Interface
REQ-001 Parameter IMG_W, default 28: input image width and height in pixels.
REQ-002 Parameter K, default 5: convolution kernel width and height.
REQ-003 Parameter DATA_W, default 8: pixel width in bits.
REQ-004 clk  input  1  Single clock; all logic is on the rising edge.
REQ-005 reset  input  1  Synchronous, active-high reset.
REQ-006 start  input  1  Starts one full-image traversal; sampled only in IDLE.
REQ-007 rd_en  output  1  Image memory read strobe.
REQ-008 rd_addr  output  10  Image memory read address.
REQ-009 rd_data  input  DATA_W  Memory data, valid exactly 1 cycle after rd_en.
REQ-010 pix_valid  output  1  Output tap valid.
REQ-011 pix_ready  input  1  Consumer (conv MAC) accepts the tap.
REQ-012 pix_data  output  DATA_W  Tap pixel value.
REQ-013 pix_last_win  output  1  Current tap is the last tap (kr=K-1, kc=K-1) of its window.
REQ-014 pix_last_img  output  1  Current tap is the last tap of the image.
REQ-015 busy  output  1  High in RUN and DRAIN.
REQ-016 done  output  1  One-cycle pulse after the final tap is accepted.

Function
REQ-017 The output side is 24x24 for the defaults (OUT_W = IMG_W-K+1); traversal order is out_row, then out_col, then kr, then kc (kc fastest); 14400 taps per image.
REQ-018 rd_addr = (out_row+kr)*IMG_W + out_col + kc; first address 0, last address 783.
REQ-019 FSM states are IDLE, RUN, DRAIN and DONE; IDLE->RUN on start; RUN->DRAIN in the cycle after the final read issues; DRAIN->DONE when the final tap handshakes; DONE->IDLE unconditionally after 1 cycle.
REQ-020 A tap transfers in the cycle where pix_valid and pix_ready are both high; pix_data and both last flags stay stable while pix_valid is high and pix_ready is low.
REQ-021 Data passes through a 2-entry buffer; rd_en asserts in RUN only when (occupancy + in-flight read - transfer this cycle) < 2; the buffer never overflows.
REQ-022 With pix_ready held high, throughput is 1 tap per cycle with no bubbles after the first tap.
REQ-023 Latency: start high in cycle T gives rd_en=1 with addr 0 in T+1, and pix_valid=1 with pix_data=mem[0] in T+3.
REQ-024 The index counters advance only when a read issues; each wraps to 0 at its limit and carries into the next index.
REQ-025 start is ignored outside IDLE; start asserted in the DONE cycle is also ignored.
REQ-026 rd_en is low in IDLE, DRAIN and DONE; rd_addr holds its last value when rd_en is low.

Reset
REQ-027 When reset is high at a clock edge:
- state returns to IDLE;
- counters and buffer occupancy clear to 0;
- rd_en, rd_addr, pix_valid, pix_data, both last flags, busy and done are all 0 after that edge.
REQ-028 Reset mid-traversal discards the in-flight read and buffered taps; the next start restarts at address 0.

Structure
REQ-029 Package cnn_pkg holds:
- IMG_W, K, OUT_W and DATA_W defaults;
- the tap count constant 14400;
- the win_state_t enum {IDLE, RUN, DRAIN, DONE}.
REQ-030 The 2-entry buffer is sub-module win_skid_buf with ports clk, reset, in_valid, in_data, in_last_win, in_last_img, occupancy, out_valid, out_ready and out_data/flags.

Verification
REQ-031 Memory preloaded with mem[i]=i mod 256, pix_ready always 1, start pulse:
- first 25 taps are 0,1,2,3,4,28,...,116, with pix_last_win on the 25th;
- 14400 taps in total, the last from address 783 (value 15) with pix_last_img=1;
- done pulses 1 cycle after the last tap.
REQ-032 pix_ready held low for the 10 cycles after start: exactly 2 reads issue, pix_valid stays 1 with pix_data=0 stable; on release, taps continue with no loss or duplication.
REQ-033 pix_ready random at 50%: the full tap stream matches the reference model in order; occupancy stays at most 2 every cycle.
REQ-034 Reset asserted at tap 500, then start: all outputs are 0 the cycle after reset, and the new traversal begins at rd_addr=0.
REQ-035 start pulsed in RUN at tap 100 and again in DONE: no restart, the tap count stays 14400, and a single done pulse is seen.
